// File: rtl/gpio_pad_ctrl.sv
// Pad-side GPIO control: registered tristate drive from the GPIO registers,
// and a two-flop synchronised, debounced pin input with per-pin edge events.
module gpio_pad_ctrl #(
  parameter int unsigned PIN_NUM         = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        reg_ctrl_i,
  input  logic [31:0]        reg_data_i,
  input  logic [PIN_NUM-1:0] pad_i,
  output logic [PIN_NUM-1:0] pad_o,
  output logic [PIN_NUM-1:0] pad_oe,
  output logic [PIN_NUM-1:0] io_pin_o,
  output logic [PIN_NUM-1:0] rise_o,
  output logic [PIN_NUM-1:0] fall_o
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_HIZ = 2'b00,
    MODE_OUT = 2'b01,
    MODE_IN  = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  logic [PIN_NUM-1:0]         s1_q, s2_q;
  logic [PIN_NUM-1:0]         stb_q, stb_d;
  logic [PIN_NUM-1:0][CW-1:0] cnt_q, cnt_d;
  logic [PIN_NUM-1:0]         pad_o_q, pad_o_d;
  logic [PIN_NUM-1:0]         pad_oe_q, pad_oe_d;
  logic [PIN_NUM-1:0]         rise_q, rise_d;
  logic [PIN_NUM-1:0]         fall_q, fall_d;
  mode_e                      mode;

  always_comb begin
    mode     = MODE_HIZ;
    stb_d    = stb_q;
    cnt_d    = cnt_q;
    pad_o_d  = '0;
    pad_oe_d = '0;
    rise_d   = '0;
    fall_d   = '0;
    for (int unsigned k = 0; k < PIN_NUM; k++) begin
      mode        = mode_e'(reg_ctrl_i[2*k +: 2]);
      pad_oe_d[k] = (mode == MODE_OUT);
      pad_o_d[k]  = (mode == MODE_OUT) && reg_data_i[k];
      // A level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
      if (s2_q[k] == stb_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CNT_LAST) begin
        stb_d[k]  = s2_q[k];
        cnt_d[k]  = '0;
        rise_d[k] = s2_q[k] && (mode == MODE_IN);
        fall_d[k] = !s2_q[k] && (mode == MODE_IN);
      end else begin
        cnt_d[k] = cnt_q[k] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stb_q    <= '0;
      cnt_q    <= '0;
      pad_o_q  <= '0;
      pad_oe_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
    end else begin
      s1_q     <= pad_i;
      s2_q     <= s1_q;
      stb_q    <= stb_d;
      cnt_q    <= cnt_d;
      pad_o_q  <= pad_o_d;
      pad_oe_q <= pad_oe_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign pad_o    = pad_o_q;
  assign pad_oe   = pad_oe_q;
  assign io_pin_o = stb_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

  // Register bits beyond the configured pins carry no function here.
  if (PIN_NUM < 16) begin : g_hi_bits
    logic unused_hi;
    assign unused_hi = ^{reg_ctrl_i[31:2*PIN_NUM], reg_data_i[31:PIN_NUM]};
  end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Bench for gpio_pad_ctrl: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_gpio_pad_ctrl;
  localparam int unsigned PN  = 2;
  localparam int unsigned DEB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   ctrl = '0;
  logic [31:0]   data = '0;
  logic [PN-1:0] pad = '0;
  logic [PN-1:0] pad_o, pad_oe, io_pin_o, rise_o, fall_o;

  always #5 clk = ~clk;

  gpio_pad_ctrl #(.PIN_NUM(PN), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk        (clk),
    .rst        (rst),
    .reg_ctrl_i (ctrl),
    .reg_data_i (data),
    .pad_i      (pad),
    .pad_o      (pad_o),
    .pad_oe     (pad_oe),
    .io_pin_o   (io_pin_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
  endtask

  // Behavioural model: pad samples pass through a 2-deep delay line, then a
  // level is accepted once DEB consecutive delayed samples disagree with it.
  logic [PN-1:0] dly [2];
  logic [PN-1:0] sync_v;
  logic [PN-1:0] m_lvl, m_oe, m_po, m_rise, m_fall;
  int            run [PN];
  logic [1:0]    m_mode;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly[0] = '0; dly[1] = '0;
      m_lvl = '0; m_oe = '0; m_po = '0; m_rise = '0; m_fall = '0;
      for (int i = 0; i < PN; i++) run[i] = 0;
    end else begin
      sync_v = dly[1];
      dly[1] = dly[0];
      dly[0] = pad;
      m_rise = '0;
      m_fall = '0;
      for (int k = 0; k < PN; k++) begin
        m_mode  = ctrl[2*k +: 2];
        m_oe[k] = (m_mode == 2'b01);
        m_po[k] = (m_mode == 2'b01) && data[k];
        if (sync_v[k] != m_lvl[k]) begin
          run[k]++;
          if (run[k] == DEB) begin
            m_lvl[k] = sync_v[k];
            run[k] = 0;
            if (m_mode == 2'b10) begin
              if (sync_v[k]) m_rise[k] = 1'b1;
              else           m_fall[k] = 1'b1;
            end
          end
        end else begin
          run[k] = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("pad_oe",   32'(pad_oe),   32'(m_oe));
    chk("pad_o",    32'(pad_o),    32'(m_po));
    chk("io_pin_o", 32'(io_pin_o), 32'(m_lvl));
    chk("rise_o",   32'(rise_o),   32'(m_rise));
    chk("fall_o",   32'(fall_o),   32'(m_fall));
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset held with pads high and both pins in output mode.
    rst = 1'b0; pad = 2'b11; ctrl = 32'h5; data = 32'h3;
    for (int i = 0; i < 3; i++) begin
      edges(1);
      chk("rst_outs", {pad_oe, pad_o, io_pin_o, rise_o, fall_o}, 32'h0);
    end
    @(negedge clk); rst = 1'b1; pad = 2'b00; ctrl = 32'h0; data = 32'h0;
    edges(10);

    // Output drive.
    @(negedge clk); ctrl = 32'h5; data = 32'h2;
    edges(1);
    chk("drv_oe", 32'(pad_oe), 32'h3);
    chk("drv_o",  32'(pad_o),  32'h2);
    @(negedge clk); ctrl = 32'h0;
    edges(1);
    chk("hiz_oe", 32'(pad_oe), 32'h0);
    chk("hiz_o",  32'(pad_o),  32'h0);

    // Debounce latency, rise then fall on pin 0.
    @(negedge clk); ctrl = 32'hA; pad = 2'b01;
    edges(5);
    chk("lat_pre_io",  32'(io_pin_o[0]), 32'h0);
    edges(1);
    chk("lat_io",      32'(io_pin_o[0]), 32'h1);
    chk("lat_rise",    32'(rise_o),      32'h1);
    edges(1);
    chk("lat_rise_end", 32'(rise_o),     32'h0);
    @(negedge clk); pad = 2'b00;
    edges(5);
    chk("fall_pre_io", 32'(io_pin_o[0]), 32'h1);
    edges(1);
    chk("fall_io",     32'(io_pin_o[0]), 32'h0);
    chk("fall_pulse",  32'(fall_o),      32'h1);
    edges(1);
    chk("fall_end",    32'(fall_o),      32'h0);

    // Glitch rejection on pin 1: 3 cycles rejected, 4 cycles accepted.
    @(negedge clk); pad = 2'b10;
    repeat (3) @(negedge clk);
    pad = 2'b00;
    edges(10);
    chk("glitch_io", 32'(io_pin_o[1]), 32'h0);
    @(negedge clk); pad = 2'b10;
    repeat (4) @(negedge clk);
    pad = 2'b00;
    edges(2);
    chk("pulse4_io", 32'(io_pin_o[1]), 32'h1);
    edges(10);

    // Event masking when pin is not in input mode.
    @(negedge clk); ctrl = 32'h0; pad = 2'b01;
    edges(6);
    chk("mask_io",   32'(io_pin_o[0]), 32'h1);
    chk("mask_rise", 32'(rise_o),      32'h0);
    @(negedge clk); ctrl = 32'h2;
    edges(3);
    chk("mask_late", 32'(rise_o), 32'h0);
    @(negedge clk); pad = 2'b00;
    edges(10);

    // Reset mid-debounce with pin 1 driving.
    @(negedge clk); ctrl = 32'h6; data = 32'h2; pad = 2'b01;
    edges(3);
    chk("pre_rst_oe", 32'(pad_oe), 32'h2);
    rst = 1'b0;
    #1;
    chk("mid_rst_outs", {pad_oe, pad_o, io_pin_o, rise_o, fall_o}, 32'h0);
    @(negedge clk); rst = 1'b1; ctrl = 32'h2;
    edges(5);
    chk("rerun_pre", 32'(io_pin_o[0]), 32'h0);
    edges(1);
    chk("rerun_io",   32'(io_pin_o[0]), 32'h1);
    chk("rerun_rise", 32'(rise_o),      32'h1);
    edges(2);

    // Randomized phase.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 15) == 0) ctrl = $urandom;
      if ($urandom_range(0, 7) == 0)  data = $urandom;
      for (int k = 0; k < PN; k++)
        if ($urandom_range(0, 7) == 0) pad[k] = ~pad[k];
    end
    @(negedge clk); rst = 1'b1;
    edges(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
